// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer. Captures two WIDTH-bit operands,
// feeds one bit pair per clock LSB-first through a 1-bit full-adder stage with
// a registered carry, and returns the reassembled sum plus carry-out.
// Optional feature macro: SERIAL_ADD_SUB_EN adds in_sub (A-B mode) and out_ovf.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             in_sub,
    output logic             out_ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_c
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_SUB_EN
    logic             ovf_q, ovf_d;
`endif

    logic sub_sel;
    logic s_bit;
    logic c_nxt;

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_SUB_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next state: capture in IDLE, one full-adder step per RUN edge, hand-off in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_SUB_EN
        ovf_d   = ovf_q;
        sub_sel = in_sub;
`else
        sub_sel = 1'b0;
`endif
        s_bit = a_q[0] ^ b_q[0] ^ c_q;
        c_nxt = (a_q[0] & b_q[0]) | (c_q & (a_q[0] | b_q[0]));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    // Subtract is A + ~B + 1; the forced carry replaces in_cin
                    b_d     = sub_sel ? ~in_b : in_b;
                    c_d     = sub_sel ? 1'b1 : in_cin;
                    sum_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = {s_bit, sum_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_nxt;
                if (cnt_q == LAST) begin
                    // On the last bit c_q is the carry into the MSB
`ifdef SERIAL_ADD_SUB_EN
                    ovf_d = c_q ^ c_nxt;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; result and serial taps are zero when not meaningful
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_sum   = (state_q == DONE) ? sum_q : '0;
        out_cout  = (state_q == DONE) ? c_q : 1'b0;
        ser_a     = (state_q == RUN) ? a_q[0] : 1'b0;
        ser_b     = (state_q == RUN) ? b_q[0] : 1'b0;
        ser_c     = (state_q == RUN) ? c_q : 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;
`endif
    end

endmodule
